regfile_wb_arbiter: RTL and testbench

//  Writeback stage directly upstream of the register file. It merges two write sources onto the

---
 rtl/regfile_wb_arbiter.sv | 160 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Merges in-order pipeline writeback and out-of-order multdiv
//            results onto the single register-file write port. Multdiv
//            results wait in a small FIFO until a writeback slot is free;
//            a per-register busy scoreboard tracks outstanding multdiv
//            destinations.
// Options  : WB_FORWARD_EN - adds a write-then-read bypass on two read ports.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int QDEPTH = 4
) (
    input  logic        clock,
    input  logic        ctrl_reset_n,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    input  logic        md_valid,
    input  logic [4:0]  md_reg,
    input  logic [31:0] md_data,
    output logic        md_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_reg,
    output logic        wb_stall,
    output logic [31:0] reg_busy,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg
`ifdef WB_FORWARD_EN
    ,
    input  logic [4:0]  ctrl_readRegA,
    input  logic [4:0]  ctrl_readRegB,
    input  logic [31:0] rf_readA,
    input  logic [31:0] rf_readB,
    output logic [31:0] fwd_readA,
    output logic [31:0] fwd_readB
`endif
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(QDEPTH);

    logic [4:0]    fifo_reg  [QDEPTH];
    logic [31:0]   fifo_data [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          md_accept;
    logic          wb_sel;
    logic          fifo_sel;
    logic          thru_sel;
    logic          push;
    logic          md_write;
    logic [4:0]    md_write_reg;
    logic [31:0]   busy_next;

    // Flow control comes from the registered count only, so a pop in the
    // same cycle never frees a slot early.
    assign md_ready  = (count < FULL_COUNT);
    assign wb_stall  = (count == FULL_COUNT);
    assign md_accept = md_valid && md_ready;

    // Fixed priority: live pipeline write, then FIFO head, then a direct
    // multdiv pass-through when nothing is queued. r0 writes never win.
    assign wb_sel   = wb_valid && (wb_reg != 5'd0);
    assign fifo_sel = !wb_sel && (count != '0);
    assign thru_sel = !wb_sel && (count == '0) && md_accept && (md_reg != 5'd0);
    assign push     = md_accept && (md_reg != 5'd0) && !thru_sel;

    assign md_write     = fifo_sel || thru_sel;
    assign md_write_reg = fifo_sel ? fifo_reg[head] : md_reg;

    // Scoreboard update: clear on a multdiv-sourced write, then set on issue
    // so a coincident issue of the same register keeps it busy.
    always_comb begin
        busy_next = reg_busy;
        if (md_write) begin
            busy_next[md_write_reg] = 1'b0;
        end
        if (issue_valid && (issue_reg != 5'd0)) begin
            busy_next[issue_reg] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // FIFO payload storage; contents are only meaningful below count.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_reg[tail]  <= md_reg;
            fifo_data[tail] <= md_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (fifo_sel) begin
                head <= head + PW'(1);
            end
            if (push && !fifo_sel) begin
                count <= count + CW'(1);
            end else if (!push && fifo_sel) begin
                count <= count - CW'(1);
            end
        end
    end

    // Registered regfile write port; address and data hold when idle.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= 5'd0;
            data_writeReg    <= 32'd0;
        end else if (wb_sel) begin
            ctrl_writeEnable <= 1'b1;
            ctrl_writeReg    <= wb_reg;
            data_writeReg    <= wb_data;
        end else if (fifo_sel) begin
            ctrl_writeEnable <= 1'b1;
            ctrl_writeReg    <= fifo_reg[head];
            data_writeReg    <= fifo_data[head];
        end else if (thru_sel) begin
            ctrl_writeEnable <= 1'b1;
            ctrl_writeReg    <= md_reg;
            data_writeReg    <= md_data;
        end else begin
            ctrl_writeEnable <= 1'b0;
        end
    end

    // Busy scoreboard register.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            reg_busy <= 32'd0;
        end else begin
            reg_busy <= busy_next;
        end
    end

`ifdef WB_FORWARD_EN
    // Bypass the write being committed this cycle to readers of the same register.
    assign fwd_readA = (ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA) &&
                        (ctrl_readRegA != 5'd0)) ? data_writeReg : rf_readA;
    assign fwd_readB = (ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB) &&
                        (ctrl_readRegB != 5'd0)) ? data_writeReg : rf_readB;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Directed self-checking bench for regfile_wb_arbiter with a
//            queue-based reference model compared on every falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int QDEPTH = 4;

    logic        clock = 1'b0;
    logic        ctrl_reset_n = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_reg = 5'd0;
    logic [31:0] wb_data = 32'd0;
    logic        md_valid = 1'b0;
    logic [4:0]  md_reg = 5'd0;
    logic [31:0] md_data = 32'd0;
    logic        md_ready;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_reg = 5'd0;
    logic        wb_stall;
    logic [31:0] reg_busy;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
`ifdef WB_FORWARD_EN
    logic [4:0]  ctrl_readRegA = 5'd0;
    logic [4:0]  ctrl_readRegB = 5'd0;
    logic [31:0] rf_readA = 32'd0;
    logic [31:0] rf_readB = 32'd0;
    logic [31:0] fwd_readA;
    logic [31:0] fwd_readB;
`endif

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    regfile_wb_arbiter #(.QDEPTH(QDEPTH)) dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .wb_valid         (wb_valid),
        .wb_reg           (wb_reg),
        .wb_data          (wb_data),
        .md_valid         (md_valid),
        .md_reg           (md_reg),
        .md_data          (md_data),
        .md_ready         (md_ready),
        .issue_valid      (issue_valid),
        .issue_reg        (issue_reg),
        .wb_stall         (wb_stall),
        .reg_busy         (reg_busy),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg)
`ifdef WB_FORWARD_EN
        ,
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .rf_readA         (rf_readA),
        .rf_readB         (rf_readB),
        .fwd_readA        (fwd_readA),
        .fwd_readB        (fwd_readB)
`endif
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic        m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    logic [31:32-32] m_dummy;
    logic [31:0] m_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One clock of the architectural rules: pick one source, update queue and scoreboard.
    task automatic model_step();
        bit          accept;
        int          clr;
        logic [31:0] nb;
        ent_t        e;
        accept = md_valid && (q.size() < QDEPTH);
        clr    = -1;
        nb     = m_busy;
        if (wb_valid && wb_reg != 0) begin
            m_we <= 1'b1; m_reg <= wb_reg; m_data <= wb_data;
            if (accept && md_reg != 0) q.push_back({md_reg, md_data});
        end else if (q.size() > 0) begin
            e = q.pop_front();
            m_we <= 1'b1; m_reg <= e.r; m_data <= e.d;
            clr = int'(e.r);
            if (accept && md_reg != 0) q.push_back({md_reg, md_data});
        end else if (accept && md_reg != 0) begin
            m_we <= 1'b1; m_reg <= md_reg; m_data <= md_data;
            clr = int'(md_reg);
        end else begin
            m_we <= 1'b0;
        end
        if (clr > 0) nb[clr] = 1'b0;
        if (issue_valid && issue_reg != 0) nb[issue_reg] = 1'b1;
        m_busy <= nb;
    endtask

    // Model state advances with the DUT clock and clears on asynchronous reset.
    always @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            q.delete();
            m_we   <= 1'b0;
            m_reg  <= 5'd0;
            m_data <= 32'd0;
            m_busy <= 32'd0;
        end else begin
            model_step();
        end
    end

    // Compare every falling edge once checking is enabled.
    always @(negedge clock) begin
        if (check_en) begin
            chk("cyc_we",    32'(ctrl_writeEnable), 32'(m_we));
            chk("cyc_reg",   32'(ctrl_writeReg),    32'(m_reg));
            chk("cyc_data",  data_writeReg,         m_data);
            chk("cyc_busy",  reg_busy,              m_busy);
            chk("cyc_ready", 32'(md_ready),         32'(q.size() < QDEPTH));
            chk("cyc_stall", 32'(wb_stall),         32'(q.size() == QDEPTH));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit wv, input logic [4:0] wr, input logic [31:0] wd,
                       input bit mv, input logic [4:0] mr, input logic [31:0] md,
                       input bit iv, input logic [4:0] ir);
        wb_valid = wv; wb_reg = wr; wb_data = wd;
        md_valid = mv; md_reg = mr; md_data = md;
        issue_valid = iv; issue_reg = ir;
        @(negedge clock);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Power-on reset
        @(negedge clock);
        @(negedge clock);
        chk("rst_we",    32'(ctrl_writeEnable), 32'd0);
        chk("rst_reg",   32'(ctrl_writeReg),    32'd0);
        chk("rst_data",  data_writeReg,         32'd0);
        chk("rst_busy",  reg_busy,              32'd0);
        chk("rst_ready", 32'(md_ready),         32'd1);
        chk("rst_stall", 32'(wb_stall),         32'd0);
        check_en = 1'b1;
        ctrl_reset_n = 1'b1;
        idle();

        // Single md result straight through with idle pipeline
        cyc(0, 0, 0, 0, 0, 0, 1, 5'd5);
        chk("t2_busy_set", 32'(reg_busy[5]), 32'd1);
        cyc(0, 0, 0, 1, 5'd5, 32'h12345678, 0, 0);
        chk("t2_we",   32'(ctrl_writeEnable), 32'd1);
        chk("t2_reg",  32'(ctrl_writeReg),    32'd5);
        chk("t2_data", data_writeReg,         32'h12345678);
        chk("t2_busy_clr", 32'(reg_busy[5]),  32'd0);
        idle();
        chk("t2_idle_we",   32'(ctrl_writeEnable), 32'd0);
        chk("t2_hold_data", data_writeReg,         32'h12345678);

        // Fill the FIFO behind a busy pipeline, then drain in order
        for (int i = 0; i < 6; i++) begin
            cyc(1, 5'(i + 1), 32'h100 + 32'(i),
                (i < 5), 5'(7 + i), 32'h700 + 32'(i),
                (i < 4), 5'(7 + i));
            chk("t3_wb_reg", 32'(ctrl_writeReg), 32'(i + 1));
            if (i >= 3) begin
                chk("t3_ready_low", 32'(md_ready), 32'd0);
                chk("t3_stall_hi",  32'(wb_stall), 32'd1);
            end
        end
        chk("t3_busy_all", reg_busy & 32'h0000_0F80, 32'h0000_0780);
        for (int k = 0; k < 4; k++) begin
            idle();
            chk("t3_drain_we",   32'(ctrl_writeEnable), 32'd1);
            chk("t3_drain_reg",  32'(ctrl_writeReg),    32'(7 + k));
            chk("t3_drain_data", data_writeReg,         32'h700 + 32'(k));
        end
        chk("t3_busy_done", reg_busy & 32'h0000_0F80, 32'd0);
        idle();
        chk("t3_no_r11", 32'(ctrl_writeEnable), 32'd0);
        chk("t3_ready",  32'(md_ready),         32'd1);

        // Simultaneous push and pop keeps occupancy
        cyc(1, 5'd1, 32'h11, 1, 5'd20, 32'h2020, 0, 0);
        cyc(0, 0, 0, 1, 5'd21, 32'h2121, 0, 0);
        chk("pp_reg", 32'(ctrl_writeReg), 32'd20);
        idle();
        chk("pp_reg2",  32'(ctrl_writeReg), 32'd21);
        chk("pp_data2", data_writeReg,      32'h2121);

        // Register 0 from both sources in the same cycle
        wb_valid = 1; wb_reg = 0; wb_data = 32'hFFFFFFFF;
        md_valid = 1; md_reg = 0; md_data = 32'hAAAA5555;
        #1;
        chk("t4_accepted", 32'(md_ready), 32'd1);
        @(negedge clock);
        chk("t4_no_we", 32'(ctrl_writeEnable), 32'd0);
        chk("t4_ready", 32'(md_ready),         32'd1);
        idle();
        chk("t4_still_no_we", 32'(ctrl_writeEnable), 32'd0);

        // Issue and completion of r9 on the same edge
        cyc(0, 0, 0, 0, 0, 0, 1, 5'd9);
        cyc(0, 0, 0, 1, 5'd9, 32'h9999, 1, 5'd9);
        chk("t5_we",   32'(ctrl_writeReg), 32'd9);
        chk("t5_busy", 32'(reg_busy[9]),   32'd1);
        idle();

`ifdef WB_FORWARD_EN
        cyc(1, 5'd3, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        ctrl_readRegA = 5'd3; rf_readA = 32'd0;
        ctrl_readRegB = 5'd4; rf_readB = 32'h44;
        #1;
        chk("t6_fwdA", fwd_readA, 32'hDEADBEEF);
        chk("t6_fwdB", fwd_readB, 32'h44);
        ctrl_readRegA = 5'd0; rf_readA = 32'h5A5A;
        #1;
        chk("t6_fwdA_r0", fwd_readA, 32'h5A5A);
        idle();
`endif

        // Reset mid-flight with three queued entries
        cyc(1, 5'd1, 32'h1, 1, 5'd12, 32'hC0, 1, 5'd12);
        cyc(1, 5'd2, 32'h2, 1, 5'd13, 32'hD0, 1, 5'd13);
        cyc(1, 5'd3, 32'h3, 1, 5'd14, 32'hE0, 1, 5'd14);
        chk("t1_pre_busy", reg_busy & 32'h0000_7000, 32'h0000_7000);
        wb_valid = 0; md_valid = 0; issue_valid = 0;
        #2;
        ctrl_reset_n = 1'b0;
        #1;
        chk("t1_we",    32'(ctrl_writeEnable), 32'd0);
        chk("t1_reg",   32'(ctrl_writeReg),    32'd0);
        chk("t1_data",  data_writeReg,         32'd0);
        chk("t1_busy",  reg_busy,              32'd0);
        chk("t1_ready", 32'(md_ready),         32'd1);
        chk("t1_stall", 32'(wb_stall),         32'd0);
        @(negedge clock);
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idle();
            chk("t1_no_replay", 32'(ctrl_writeEnable), 32'd0);
        end

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
